// File: rtl/crack_pkg.sv
// Shared types and constants for the ARC4 key-sweep controller.
// Holds the sweep FSM state type, the length-byte address and the printable-range defaults.
package crack_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        CHECK,
        DRAIN,
        DONE
    } sweep_state_e;

    localparam int         PT_LEN_ADDR      = 0;
    localparam logic [7:0] PRINT_LO_DEFAULT = 8'h20;
    localparam logic [7:0] PRINT_HI_DEFAULT = 8'h7E;

    function automatic logic in_print_range(input logic [7:0] b,
                                            input logic [7:0] lo,
                                            input logic [7:0] hi);
        return (b >= lo) && (b <= hi);
    endfunction

endpackage

// File: rtl/crack_sweep_if.sv
// Launch/snoop bundle between the sweep controller (master) and one ARC4 decrypt core (slave).
interface crack_sweep_if #(
    parameter int KEY_W = 24,
    parameter int LEN_W = 8
);
    logic             core_en;
    logic             core_rdy;
    logic [KEY_W-1:0] core_key;
    logic             pt_wren;
    logic [LEN_W-1:0] pt_addr;
    logic [7:0]       pt_wrdata;

    modport master (
        output core_en, core_key,
        input  core_rdy, pt_wren, pt_addr, pt_wrdata
    );

    modport slave (
        input  core_en, core_key,
        output core_rdy, pt_wren, pt_addr, pt_wrdata
    );
endinterface

// File: rtl/crack_sweep_pt_checker.sv
// Snoops the core's plaintext writes: captures the length byte and flags any
// in-range byte that is not printable. Restarted by i_clear on every launch.
module pt_checker
    import crack_pkg::*;
#(
    parameter int         LEN_W    = 8,
    parameter logic [7:0] PRINT_LO = PRINT_LO_DEFAULT,
    parameter logic [7:0] PRINT_HI = PRINT_HI_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_wren,
    input  logic [LEN_W-1:0] i_addr,
    input  logic [7:0]       i_data,
    output logic [LEN_W-1:0] o_len,
    output logic             o_bad
);

    logic [LEN_W-1:0] r_len;
    logic             r_bad;

    // Bytes beyond the captured length are padding and never count against the key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= '0;
            r_bad <= 1'b0;
        end else if (i_clear) begin
            r_len <= '0;
            r_bad <= 1'b0;
        end else if (i_wren) begin
            if (i_addr == LEN_W'(PT_LEN_ADDR)) begin
                r_len <= LEN_W'(i_data);
            end else if (i_addr <= r_len && !in_print_range(i_data, PRINT_LO, PRINT_HI)) begin
                r_bad <= 1'b1;
            end
        end
    end

    assign o_len = r_len;
    assign o_bad = r_bad;

endmodule

// File: rtl/crack_sweep.sv
// Key-sweep controller: launches one ARC4 decrypt per candidate key (start, start+stride, ... <= last)
// and stops on the first fully printable plaintext, exhaustion or abort. CRACK_SWEEP_STATS_EN adds a launch counter.
module crack_sweep
    import crack_pkg::*;
#(
    parameter int         KEY_W    = 24,
    parameter int         LEN_W    = 8,
    parameter logic [7:0] PRINT_LO = PRINT_LO_DEFAULT,
    parameter logic [7:0] PRINT_HI = PRINT_HI_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             rdy,
    input  logic [KEY_W-1:0] key_start,
    input  logic [KEY_W-1:0] key_stride,
    input  logic [KEY_W-1:0] key_last,
    input  logic             abort,
    crack_sweep_if.master    core,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic [KEY_W-1:0] attempts
);

    sweep_state_e     r_state, w_nextState;
    logic [KEY_W-1:0] r_cur, r_stride, r_last, r_key;
    logic             r_keyValid, r_busySeen;
    logic             w_accept, w_launch, w_bad, w_stop, w_chkBad;
    logic [LEN_W-1:0] w_len;
    logic [KEY_W:0]   w_nxt;

    pt_checker #(
        .LEN_W   (LEN_W),
        .PRINT_LO(PRINT_LO),
        .PRINT_HI(PRINT_HI)
    ) u_pt_checker (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clear(w_launch),
        .i_wren (core.pt_wren),
        .i_addr (core.pt_addr),
        .i_data (core.pt_wrdata),
        .o_len  (w_len),
        .o_bad  (w_chkBad)
    );

    assign rdy           = (r_state == IDLE) || (r_state == DONE);
    assign w_accept      = rdy && en;
    assign w_launch      = (r_state == LAUNCH) && core.core_rdy && !abort;
    assign core.core_en  = w_launch;
    assign core.core_key = r_cur;
    assign key           = r_key;
    assign key_valid     = r_keyValid;

    // An empty message is never accepted as a plaintext hit
    assign w_bad  = w_chkBad || (w_len == '0);
    assign w_nxt  = {1'b0, r_cur} + {1'b0, r_stride};
    assign w_stop = w_nxt[KEY_W] || (w_nxt[KEY_W-1:0] > r_last) || (r_cur == r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, DONE: if (en) w_nextState = LAUNCH;
            LAUNCH: begin
                if (abort)              w_nextState = DONE;
                else if (core.core_rdy) w_nextState = WAIT;
            end
            WAIT: begin
                if (abort)                            w_nextState = DRAIN;
                else if (r_busySeen && core.core_rdy) w_nextState = CHECK;
            end
            CHECK: begin
                if (abort || !w_bad || w_stop) w_nextState = DONE;
                else                           w_nextState = LAUNCH;
            end
            DRAIN:   if (core.core_rdy) w_nextState = DONE;
            default: w_nextState = IDLE;
        endcase
    end

    // Sweep bounds are captured once per run; a zero stride would never advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur      <= '0;
            r_stride   <= '0;
            r_last     <= '0;
            r_key      <= '0;
            r_keyValid <= 1'b0;
            r_busySeen <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cur      <= key_start;
                r_stride   <= (key_stride == '0) ? KEY_W'(1) : key_stride;
                r_last     <= key_last;
                r_keyValid <= 1'b0;
            end
            if (r_state == CHECK && !abort) begin
                if (!w_bad) begin
                    r_key      <= r_cur;
                    r_keyValid <= 1'b1;
                end else if (!w_stop) begin
                    r_cur <= w_nxt[KEY_W-1:0];
                end
            end
            if (w_launch)                                 r_busySeen <= 1'b0;
            else if (r_state == WAIT && !core.core_rdy)   r_busySeen <= 1'b1;
        end
    end

`ifdef CRACK_SWEEP_STATS_EN
    logic [KEY_W-1:0] r_attempts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             r_attempts <= '0;
        else if (w_accept)                      r_attempts <= '0;
        else if (w_launch && r_attempts != '1)  r_attempts <= r_attempts + KEY_W'(1);
    end

    assign attempts = r_attempts;
`else
    assign attempts = '0;
`endif

endmodule

// File: tb/tb_crack_sweep.sv
// Self-checking bench for crack_sweep: a behavioural ARC4 core model with a launch-key scoreboard,
// a vector table of sweeps, and hand sequences for abort/drain, en-vs-abort and reset mid-run.
module tb_crack_sweep;

    localparam int KW = 24;
`ifdef CRACK_SWEEP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [KW-1:0] start;
        logic [KW-1:0] stride;
        logic [KW-1:0] last;
        int            passKey;
        int            mode;
        bit            expFound;
        logic [KW-1:0] expKey;
        int            expLaunches;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n, en, abort, rdy, key_valid;
    logic [KW-1:0] key_start, key_stride, key_last, key, attempts;

    int            passCount = 0;
    int            totalCount = 0;
    int            launches = 0;
    int            passKey = -1;
    int            msgMode = 0;
    int            extraBusy = 0;
    logic [KW-1:0] expQ[$];
    vec_t          vecs[12];

    crack_sweep_if #(.KEY_W(KW), .LEN_W(8)) coreBus ();

    crack_sweep #(.KEY_W(KW), .LEN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .key_start (key_start),
        .key_stride(key_stride),
        .key_last  (key_last),
        .abort     (abort),
        .core      (coreBus),
        .key       (key),
        .key_valid (key_valid),
        .attempts  (attempts)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic failNow(input string name);
        totalCount++;
        $display("[TB] FAIL %s", name);
    endtask

    function automatic bit keyPasses(input logic [KW-1:0] k);
        case (msgMode)
            0:       return int'(k) == passKey;
            3, 4:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference sweep order: every candidate the controller must launch, in order
    task automatic buildExpected(input vec_t v);
        logic [KW-1:0] k;
        logic [KW-1:0] st;
        logic [KW:0]   n;
        k  = v.start;
        st = (v.stride == 0) ? 24'd1 : v.stride;
        for (int i = 0; i < 64; i++) begin
            expQ.push_back(k);
            if (keyPasses(k)) break;
            n = {1'b0, k} + {1'b0, st};
            if (n[KW] || n[KW-1:0] > v.last || k == v.last) break;
            k = n[KW-1:0];
        end
    endtask

    // Behavioural ARC4 core: goes busy after a launch, writes length + message, then returns ready
    initial begin
        logic [7:0]    msg[$];
        logic [KW-1:0] k;
        coreBus.core_rdy  = 1'b1;
        coreBus.pt_wren   = 1'b0;
        coreBus.pt_addr   = '0;
        coreBus.pt_wrdata = '0;
        forever begin
            @(negedge clk); #2;
            if (rst_n === 1'b1 && coreBus.core_en === 1'b1) begin
                launches++;
                k = coreBus.core_key;
                if (expQ.size() == 0) failNow($sformatf("launchUnexpected key=%0h", k));
                else checkVal($sformatf("launchKey%0d", launches), 32'(k), 32'(expQ.pop_front()));
                case (msgMode)
                    0:       msg = keyPasses(k) ? '{8'd4, 8'h54, 8'h65, 8'h73, 8'h74}
                                                : '{8'd3, 8'h4F, 8'h05, 8'h4B};
                    1:       msg = '{8'd0};
                    2:       msg = '{8'd4, 8'h61, 8'h7F, 8'h63, 8'h64};
                    3:       msg = '{8'd4, 8'h61, 8'h62, 8'h63, 8'h64, 8'h7F};
                    4:       msg = '{8'd2, 8'h20, 8'h7E};
                    default: msg = '{8'd1, 8'h1F};
                endcase
                @(negedge clk); #2;
                coreBus.core_rdy = 1'b0;
                foreach (msg[i]) begin
                    coreBus.pt_wren   = 1'b1;
                    coreBus.pt_addr   = 8'(i);
                    coreBus.pt_wrdata = msg[i];
                    @(negedge clk); #2;
                end
                coreBus.pt_wren = 1'b0;
                repeat (extraBusy) begin @(negedge clk); #2; end
                coreBus.core_rdy = 1'b1;
            end
        end
    end

    task automatic waitIdle(input string name);
        int n = 0;
        while (rdy !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        if (rdy !== 1'b1) failNow({name, "_timeout"});
    endtask

    task automatic startSweep(input logic [KW-1:0] s, input logic [KW-1:0] st,
                              input logic [KW-1:0] l, input logic ab);
        @(negedge clk);
        key_start = s; key_stride = st; key_last = l; en = 1'b1; abort = ab;
        @(negedge clk);
        en = 1'b0; abort = 1'b0;
    endtask

    task automatic applyStimulus(input int idx);
        vec_t v = vecs[idx];
        passKey = v.passKey; msgMode = v.mode; extraBusy = 0;
        launches = 0; expQ.delete();
        buildExpected(v);
        startSweep(v.start, v.stride, v.last, 1'b0);
        checkVal($sformatf("v%0d_rdyDrop", idx), 32'(rdy), 0);
        checkVal($sformatf("v%0d_kvClear", idx), 32'(key_valid), 0);
        waitIdle($sformatf("v%0d", idx));
    endtask

    task automatic checkOutput(input int idx);
        vec_t v = vecs[idx];
        checkVal($sformatf("v%0d_keyValid", idx), 32'(key_valid), 32'(v.expFound));
        if (v.expFound) checkVal($sformatf("v%0d_key", idx), 32'(key), 32'(v.expKey));
        checkVal($sformatf("v%0d_launches", idx), launches, v.expLaunches);
        checkVal($sformatf("v%0d_attempts", idx), 32'(attempts), STATS ? v.expLaunches : 0);
        checkVal($sformatf("v%0d_sbEmpty", idx), expQ.size(), 0);
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        vecs[0]  = '{24'd0,       24'd1, 24'd5,       3,  0, 1'b1, 24'd3, 4};
        vecs[1]  = '{24'd2,       24'd4, 24'd20,      -1, 0, 1'b0, 24'd0, 5};
        vecs[2]  = '{24'hFFFFFE,  24'd3, 24'hFFFFFF,  -1, 0, 1'b0, 24'd0, 1};
        vecs[3]  = '{24'd7,       24'd0, 24'd9,       9,  0, 1'b1, 24'd9, 3};
        vecs[4]  = '{24'd10,      24'd1, 24'd5,       -1, 0, 1'b0, 24'd0, 1};
        vecs[5]  = '{24'd0,       24'd1, 24'd1,       -1, 1, 1'b0, 24'd0, 2};
        vecs[6]  = '{24'd0,       24'd1, 24'd0,       -1, 2, 1'b0, 24'd0, 1};
        vecs[7]  = '{24'd4,       24'd1, 24'd6,       -1, 3, 1'b1, 24'd4, 1};
        vecs[8]  = '{24'd0,       24'd1, 24'd0,       -1, 4, 1'b1, 24'd0, 1};
        vecs[9]  = '{24'hFFFFF0,  24'd8, 24'hFFFFFF,  -1, 0, 1'b0, 24'd0, 2};
        vecs[10] = '{24'd0,       24'd1, 24'd0,       -1, 5, 1'b0, 24'd0, 1};
        vecs[11] = '{24'd0,       24'd2, 24'd4,       -1, 0, 1'b0, 24'd0, 3};

        rst_n = 1'b0; en = 1'b0; abort = 1'b0;
        key_start = '0; key_stride = '0; key_last = '0;
        #12;
        checkVal("rst_rdy", 32'(rdy), 1);
        checkVal("rst_coreEn", 32'(coreBus.core_en), 0);
        checkVal("rst_coreKey", 32'(coreBus.core_key), 0);
        checkVal("rst_key", 32'(key), 0);
        checkVal("rst_keyValid", 32'(key_valid), 0);
        checkVal("rst_attempts", 32'(attempts), 0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(i);
            checkOutput(i);
        end

        // en and abort together while ready: the start request wins
        passKey = 3; msgMode = 0; extraBusy = 0; launches = 0; expQ.delete();
        expQ.push_back(24'd3);
        startSweep(24'd3, 24'd1, 24'd3, 1'b1);
        waitIdle("enAbort");
        checkVal("enAbort_keyValid", 32'(key_valid), 1);
        checkVal("enAbort_key", 32'(key), 3);
        checkVal("enAbort_launches", launches, 1);

        // Abort while the core is busy on key 1: must drain, then stop without relaunching
        passKey = -1; msgMode = 0; extraBusy = 10; launches = 0; expQ.delete();
        expQ.push_back(24'd0); expQ.push_back(24'd1);
        startSweep(24'd0, 24'd1, 24'd5, 1'b0);
        n = 0;
        while (launches < 2 && n < 2000) begin @(negedge clk); n++; end
        if (launches < 2) failNow("abort_waitLaunch_timeout");
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        checkVal("abort_drainHold", 32'(rdy), 0);
        waitIdle("abort");
        checkVal("abort_coreRdyAtDone", 32'(coreBus.core_rdy), 1);
        repeat (5) @(negedge clk);
        checkVal("abort_keyValid", 32'(key_valid), 0);
        checkVal("abort_launches", launches, 2);
        checkVal("abort_attempts", 32'(attempts), STATS ? 2 : 0);
        checkVal("abort_sbEmpty", expQ.size(), 0);

        // Reset asserted while the core is mid-run
        passKey = -1; msgMode = 0; extraBusy = 10; launches = 0; expQ.delete();
        expQ.push_back(24'd5);
        startSweep(24'd5, 24'd1, 24'd9, 1'b0);
        n = 0;
        while (launches < 1 && n < 2000) begin @(negedge clk); n++; end
        if (launches < 1) failNow("rstWait_launch_timeout");
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkVal("rstWait_rdy", 32'(rdy), 1);
        checkVal("rstWait_coreEn", 32'(coreBus.core_en), 0);
        checkVal("rstWait_coreKey", 32'(coreBus.core_key), 0);
        checkVal("rstWait_key", 32'(key), 0);
        checkVal("rstWait_keyValid", 32'(key_valid), 0);
        checkVal("rstWait_attempts", 32'(attempts), 0);
        n = 0;
        while (coreBus.core_rdy !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        if (coreBus.core_rdy !== 1'b1) failNow("rstWait_coreDone_timeout");
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkVal("rstWait_idleRdy", 32'(rdy), 1);
        checkVal("rstWait_launches", launches, 1);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/crack_sweep.md
Name: crack_sweep

Overview:
Parametrised key-sweep controller for the ARC4 cracking path; successor to the single-range cracker.
- Iterates candidate keys from key_start to key_last in steps of key_stride, so several sweeps can split the key space by offset/stride.
- For each candidate it launches one ARC4 decrypt core and snoops the core's plaintext writes.
- It stops on the first key whose whole message is printable, on range exhaustion, or on an external abort (e.g. a sibling lane found the key).

Parameters:
KEY_W, 24, key width in bits
LEN_W, 8, plaintext address/length width
PRINT_LO, 8'h20, lowest acceptable plaintext byte
PRINT_HI, 8'h7E, highest acceptable plaintext byte

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  start request; honoured only while rdy=1
rdy  out  1  high when idle/finished and able to accept en
key_start  in  KEY_W  first candidate, latched on accepted en
key_stride  in  KEY_W  increment, latched on accepted en; 0 treated as 1
key_last  in  KEY_W  last candidate allowed (inclusive), latched on accepted en
abort  in  1  stop request from outside (sibling found / host)
core_en  out  1  one-cycle launch pulse to ARC4 core
core_rdy  in  1  ARC4 core ready; low while decrypting
core_key  out  KEY_W  candidate key presented to core, stable from launch until core returns rdy
pt_wren  in  1  snooped core plaintext write strobe
pt_addr  in  LEN_W  snooped write address; addr 0 carries length byte
pt_wrdata  in  8  snooped write data
key  out  KEY_W  winning key, valid when key_valid=1
key_valid  out  1  high in DONE if a key was found
attempts  out  KEY_W  number of launched candidates (see Optional Feature)

Behaviour:
- Reset: rdy=1, core_en=0, core_key=0, key=0, key_valid=0, attempts=0, state IDLE, all flags cleared.
- States: IDLE, LAUNCH, WAIT, CHECK, DRAIN, DONE.
- IDLE/DONE, rdy=1: en=1 latches start/stride/last, cur=key_start, clears key_valid; next state LAUNCH. rdy drops the following cycle.
- LAUNCH:
  - Waits for core_rdy=1, then drives core_en=1 for exactly one cycle with core_key=cur.
  - Clears len, bad and busy_seen; next state WAIT.
- WAIT:
  - busy_seen sets when core_rdy=0 is sampled.
  - Each pt_wren with pt_addr=0 captures len=pt_wrdata.
  - Each pt_wren with 1<=pt_addr<=len and pt_wrdata outside [PRINT_LO,PRINT_HI] sets bad.
  - Writes with pt_addr>len are ignored.
  - Exit to CHECK when busy_seen=1 and core_rdy=1.
- CHECK (one cycle):
  - len=0 counts as bad.
  - If !bad: key<=cur, key_valid<=1, go DONE.
  - Else compute nxt=cur+stride in KEY_W+1 bits. If carry or nxt>key_last or cur==key_last, go DONE with key_valid=0. Otherwise cur<=nxt and go LAUNCH.
- abort, sampled in LAUNCH/CHECK: go DONE with key_valid=0 on the next edge.
- abort in WAIT: go DRAIN. DRAIN waits for core_rdy=1 (core never left mid-run), then goes to DONE with key_valid=0.
- abort in IDLE/DONE: ignored. abort and en high together while rdy=1: en wins.
- key_start>key_last: one launch with key_start only, then DONE.
- Launch-to-check latency = core runtime + 1 cycle; CHECK-to-next-launch = 1 cycle when core_rdy already high.
- key/key_valid hold in DONE until the next accepted en.

Optional Feature:
- Macro: CRACK_SWEEP_STATS_EN.
- When defined: attempts increments by 1 on every core_en pulse, clears on accepted en, saturates at all-ones.
- When undefined: attempts is tied to 0 and no counter is synthesised; the port stays present so integration code is unchanged.

Decomposition:
- Package crack_pkg holds:
  - state enum sweep_state_e {IDLE, LAUNCH, WAIT, CHECK, DRAIN, DONE}
  - localparams PT_LEN_ADDR=0, PRINT_LO/PRINT_HI defaults
- One natural sub-module, pt_checker: snoops pt_wren/addr/data and produces len and bad. It has a clear input to restart it on each launch.

Test Plan:
- start=0, stride=1, last=5; core model passes only key 3 → launches keys 0,1,2,3; key=3, key_valid=1, attempts=4, rdy=1.
- start=2, stride=4, last=20; nothing passes → keys 2,6,10,14,18 launched; DONE with key_valid=0, attempts=5.
- start=24'hFFFFFE, stride=3, last=24'hFFFFFF; all fail → one launch, carry detected, DONE with key_valid=0.
- abort raised mid-WAIT on key 1 → FSM waits in DRAIN until core_rdy=1, no further core_en, key_valid=0.
- Core writes len=0 then no bytes → treated as bad; byte 8'h7F at addr 2 of len=4 → bad; byte 8'h7F at addr 5 of len=4 → ignored, key passes.
- rst_n low while in WAIT → all outputs at reset values immediately. Without CRACK_SWEEP_STATS_EN, attempts stays 0 throughout.
